egress_arbiter: RTL and testbench

- Shares the single switch egress AXI-Stream interface among NUM_REQ switch requesters, one per ingress filter path.
- Arbitrates round-robin at frame granularity. A grant is held from the first accepted beat until the tlast handshake, or until the granted requester goes silent past a timeout.
- Sits between the per-port switch requesters and the switch egress port. It is a pass-through mux plus a grant state machine and adds no data buffering.

---
 rtl/egress_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_egress_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/egress_arbiter.sv
// Frame-granular round-robin arbiter muxing NUM_REQ AXI-Stream requesters onto one egress port.
// Optional per-port statistics counters are built when EGRESS_ARB_STATS_EN is defined.

`ifndef AXIS_DEST_WIDTH
`define AXIS_DEST_WIDTH 4
`endif

`ifdef EGRESS_ARB_STATS_EN
module egress_arbiter_stat_lane #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (inc && count != '1)
            count <= count + W'(1);
    end
endmodule
`endif

module egress_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int DEST_WIDTH   = `AXIS_DEST_WIDTH,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata,
    input  logic [NUM_REQ*DEST_WIDTH-1:0] req_tdest,
    input  logic [NUM_REQ-1:0]            req_tvalid,
    input  logic [NUM_REQ-1:0]            req_tlast,
    output logic [NUM_REQ-1:0]            req_tready,
    output logic [DATA_WIDTH-1:0]         egress_tdata,
    output logic [DEST_WIDTH-1:0]         egress_tdest,
    output logic                          egress_tvalid,
    output logic                          egress_tlast,
    input  logic                          egress_tready,
    output logic [NUM_REQ-1:0]            grant_onehot,
    output logic                          busy
`ifdef EGRESS_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]         stat_frames,
    output logic [NUM_REQ*8-1:0]          stat_timeouts
`endif
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                             state, state_nxt;
    logic [IDX_W-1:0]                   rr_ptr, rr_nxt;
    logic [IDX_W-1:0]                   grant_idx, idx_nxt;
    logic [NUM_REQ-1:0]                 grant_nxt;
    logic [7:0]                         timeout_ctr, ctr_nxt;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_a;
    logic [NUM_REQ-1:0][DEST_WIDTH-1:0] dest_a;
    logic [IDX_W-1:0]                   pick_idx;
    logic                               pick_vld;
    logic                               g_valid, hs_last, to_hit, release_now;

    assign data_a = req_tdata;
    assign dest_a = req_tdest;

    // Egress mux is AND-OR gated by the registered grant, so an idle or reset
    // arbiter drives all zeros without any extra state qualification.
    always_comb begin
        egress_tdata = '0;
        egress_tdest = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_onehot[i]) begin
                egress_tdata = egress_tdata | data_a[i];
                egress_tdest = egress_tdest | dest_a[i];
            end
        end
    end

    assign egress_tvalid = |(grant_onehot & req_tvalid);
    assign egress_tlast  = |(grant_onehot & req_tlast);
    assign req_tready    = grant_onehot & {NUM_REQ{egress_tready}};
    assign busy          = (state == LOCKED);

    assign g_valid     = req_tvalid[grant_idx];
    assign hs_last     = egress_tvalid & egress_tready & egress_tlast;
    assign to_hit      = (state == LOCKED) && !g_valid && (timeout_ctr == 8'(IDLE_TIMEOUT - 1));
    assign release_now = (state == LOCKED) && (hs_last || to_hit);

    // Search upward from rr_ptr with wrap; first valid requester wins.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cidx;
        cand     = 0;
        cidx     = '0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ)
                cand = cand - NUM_REQ;
            cidx = IDX_W'(cand);
            if (!pick_vld && req_tvalid[cidx]) begin
                pick_vld = 1'b1;
                pick_idx = cidx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        idx_nxt   = grant_idx;
        grant_nxt = grant_onehot;
        ctr_nxt   = timeout_ctr;
        case (state)
            IDLE: begin
                ctr_nxt = '0;
                if (pick_vld) begin
                    state_nxt           = LOCKED;
                    idx_nxt             = pick_idx;
                    grant_nxt           = '0;
                    grant_nxt[pick_idx] = 1'b1;
                end
            end
            LOCKED: begin
                if (release_now) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    ctr_nxt   = '0;
                    if (int'(grant_idx) == NUM_REQ - 1)
                        rr_nxt = '0;
                    else
                        rr_nxt = grant_idx + IDX_W'(1);
                end else if (g_valid) begin
                    // Backpressure keeps tvalid high, so it never counts as idle.
                    ctr_nxt = '0;
                end else begin
                    ctr_nxt = timeout_ctr + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_idx    <= '0;
            grant_onehot <= '0;
            timeout_ctr  <= '0;
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_nxt;
            grant_idx    <= idx_nxt;
            grant_onehot <= grant_nxt;
            timeout_ctr  <= ctr_nxt;
        end
    end

`ifdef EGRESS_ARB_STATS_EN
    logic [NUM_REQ-1:0] frame_inc, to_inc;

    assign frame_inc = (state == LOCKED && hs_last) ? grant_onehot : '0;
    assign to_inc    = to_hit ? grant_onehot : '0;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        egress_arbiter_stat_lane #(.W(16)) u_frames (
            .clk    (clk),
            .reset_n(reset_n),
            .inc    (frame_inc[i]),
            .count  (stat_frames[i*16 +: 16])
        );
        egress_arbiter_stat_lane #(.W(8)) u_timeouts (
            .clk    (clk),
            .reset_n(reset_n),
            .inc    (to_inc[i]),
            .count  (stat_timeouts[i*8 +: 8])
        );
    end
`endif
endmodule

// File: tb/tb_egress_arbiter.sv
// Directed scoreboard bench for egress_arbiter: per-port source queues feed the DUT,
// expected beats and grant order are queued up front and checked as the DUT produces them.
module tb_egress_arbiter;
    localparam int NR = 4;
    localparam int DW = 16;
    localparam int TW = 4;

    typedef struct packed {
        logic          last;
        logic [TW-1:0] dest;
        logic [DW-1:0] data;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NR*DW-1:0] req_tdata;
    logic [NR*TW-1:0] req_tdest;
    logic [NR-1:0]    req_tvalid;
    logic [NR-1:0]    req_tlast;
    logic [NR-1:0]    req_tready;
    logic [DW-1:0]    egress_tdata;
    logic [TW-1:0]    egress_tdest;
    logic             egress_tvalid;
    logic             egress_tlast;
    logic             egress_tready;
    logic [NR-1:0]    grant_onehot;
    logic             busy;
`ifdef EGRESS_ARB_STATS_EN
    logic [NR*16-1:0] stat_frames;
    logic [NR*8-1:0]  stat_timeouts;
`endif

    egress_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEST_WIDTH(TW), .IDLE_TIMEOUT(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_tdata    (req_tdata),
        .req_tdest    (req_tdest),
        .req_tvalid   (req_tvalid),
        .req_tlast    (req_tlast),
        .req_tready   (req_tready),
        .egress_tdata (egress_tdata),
        .egress_tdest (egress_tdest),
        .egress_tvalid(egress_tvalid),
        .egress_tlast (egress_tlast),
        .egress_tready(egress_tready),
        .grant_onehot (grant_onehot),
        .busy         (busy)
`ifdef EGRESS_ARB_STATS_EN
        ,
        .stat_frames  (stat_frames),
        .stat_timeouts(stat_timeouts)
`endif
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    beat_t         src_q [NR][$];
    beat_t         exp_q [$];
    logic [NR-1:0] gnt_q [$];
    logic [NR-1:0] presented = '0;
    logic [NR-1:0] hs_n = '0;
    bit            flush = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int p, input int f, input int b);
        return {4'(p), 4'(f), 8'(b)};
    endfunction

    function automatic beat_t bt(input int p, input int f, input int b, input bit last);
        beat_t r;
        r.last = last;
        r.dest = TW'(p * 5 + f);
        r.data = mk(p, f, b);
        return r;
    endfunction

    task automatic push_src(input int p, input int f, input int n, input bit closed);
        for (int b = 0; b < n; b++)
            src_q[p].push_back(bt(p, f, b, closed && (b == n - 1)));
    endtask

    task automatic push_exp(input int p, input int f, input int n, input bit closed);
        for (int b = 0; b < n; b++)
            exp_q.push_back(bt(p, f, b, closed && (b == n - 1)));
    endtask

    function automatic bit src_empty();
        bit e = 1;
        for (int i = 0; i < NR; i++)
            if (src_q[i].size() != 0) e = 0;
        return e;
    endfunction

    task automatic wait_drain(input string tag);
        int n = 0;
        bit ok = 0;
        while (n < 300 && !ok) begin
            @(negedge clk);
            n++;
            ok = (grant_onehot == '0) && (exp_q.size() == 0) && src_empty();
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_beat(input logic [DW-1:0] d, input string tag);
        int n = 0;
        bit ok = 0;
        while (n < 30 && !ok) begin
            @(negedge clk);
            n++;
            ok = egress_tvalid && (egress_tdata == d);
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    always @(posedge clk) cyc++;

    // Requesters: capture handshakes away from the edge, advance just after it.
    always @(negedge clk) hs_n = req_tvalid & req_tready;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NR; i++) begin
            if (flush) begin
                src_q[i].delete();
                presented[i] = 1'b0;
            end else if (presented[i] && hs_n[i]) begin
                src_q[i].delete(0);
            end
            if (!flush && src_q[i].size() > 0) begin
                presented[i]            = 1'b1;
                req_tvalid[i]           = 1'b1;
                req_tlast[i]            = src_q[i][0].last;
                req_tdata[i*DW +: DW]   = src_q[i][0].data;
                req_tdest[i*TW +: TW]   = src_q[i][0].dest;
            end else begin
                presented[i]  = 1'b0;
                req_tvalid[i] = 1'b0;
                req_tlast[i]  = 1'b0;
            end
        end
        flush = 0;
    end

    // Scoreboard and protocol monitor.
    logic [NR-1:0] prev_gnt = '0;
    bit            prev_last = 0;
    bit            prev_wait = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_gnt  = '0;
            prev_last = 0;
            prev_wait = 0;
        end else begin
            if (prev_last)
                chk("bubble_after_tlast", {grant_onehot, busy}, 32'd0);
            if (prev_wait)
                chk("grant_latency", 32'(grant_onehot != '0), 32'd1);
            if ((req_tvalid & ~grant_onehot) != '0)
                chk("tready_ungranted", 32'(req_tready & ~grant_onehot), 32'd0);
            if (grant_onehot != '0 && grant_onehot != prev_gnt) begin
                if (gnt_q.size() == 0)
                    chk("grant_unexpected", 32'(grant_onehot), 32'd0);
                else
                    chk("grant_order", 32'(grant_onehot), 32'(gnt_q.pop_front()));
            end
            if (egress_tvalid && egress_tready) begin
                if (exp_q.size() == 0)
                    chk("beat_unexpected", 32'(egress_tvalid), 32'd0);
                else
                    chk("beat", 32'({egress_tlast, egress_tdest, egress_tdata}), 32'(exp_q.pop_front()));
            end
            prev_last = egress_tvalid && egress_tready && egress_tlast;
            prev_wait = (grant_onehot == '0) && (req_tvalid != '0);
            prev_gnt  = grant_onehot;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  c0, c1, n;
        bit  ok;
        reset_n       = 1'b0;
        egress_tready = 1'b1;
        req_tdata     = '0;
        req_tdest     = '0;
        req_tvalid    = '0;
        req_tlast     = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant_onehot), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tvalid", 32'(egress_tvalid), 32'd0);
        chk("rst_tready", 32'(req_tready), 32'd0);
        chk("rst_tdata", 32'({egress_tlast, egress_tdest, egress_tdata}), 32'd0);
        #2 reset_n = 1'b1;
        @(negedge clk);

        // Ports 0, 1, 3 continuously valid, two 3-beat frames each.
        gnt_q = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        for (int f = 0; f < 2; f++) begin
            push_src(0, f, 3, 1); push_src(1, f, 3, 1); push_src(3, f, 3, 1);
        end
        for (int f = 0; f < 2; f++) begin
            push_exp(0, f, 3, 1); push_exp(1, f, 3, 1); push_exp(3, f, 3, 1);
        end
        wait_drain("rr_three_ports_drain");

        // Port 2 alone, 5-beat frame.
        gnt_q.push_back(4'b0100);
        push_src(2, 1, 5, 1);
        push_exp(2, 1, 5, 1);
        @(negedge clk);
        chk("s1_pre_grant", 32'(grant_onehot), 32'd0);
        @(negedge clk);
        chk("s1_grant", 32'(grant_onehot), 32'b0100);
        chk("s1_busy", 32'(busy), 32'd1);
        wait_drain("s1_drain");

        // Port 1 with 40 cycles of egress backpressure mid-frame.
        gnt_q.push_back(4'b0010);
        push_src(1, 3, 4, 1);
        push_exp(1, 3, 4, 1);
        wait_beat(mk(1, 3, 1), "bp_reach_beat1");
        @(posedge clk);
        #1 egress_tready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("bp_data_stable", 32'(egress_tdata), 32'(mk(1, 3, 2)));
            chk("bp_grant_held", 32'(grant_onehot), 32'b0010);
        end
        @(posedge clk);
        #1 egress_tready = 1'b1;
        wait_drain("bp_drain");

        // Port 0 sends 2 beats then goes silent: timeout release.
        gnt_q.push_back(4'b0001);
        push_src(0, 4, 2, 0);
        push_exp(0, 4, 2, 0);
        n = 0; ok = 0;
        while (n < 30 && !ok) begin
            @(negedge clk);
            n++;
            ok = (grant_onehot == 4'b0001) && !req_tvalid[0];
        end
        chk("to_silent_seen", 32'(ok), 32'd1);
        c0 = cyc;
        n = 0; ok = 0;
        while (n < 60 && !ok) begin
            @(negedge clk);
            n++;
            ok = (grant_onehot == '0);
        end
        c1 = cyc;
        chk("to_released", 32'(ok), 32'd1);
        chk("to_cycles", 32'(c1 - c0), 32'd16);
`ifdef EGRESS_ARB_STATS_EN
        chk("stat_timeouts0", 32'(stat_timeouts[7:0]), 32'd1);
`endif
        // rr_ptr must now be 1: port 2 beats port 0.
        gnt_q.push_back(4'b0100);
        gnt_q.push_back(4'b0001);
        push_src(0, 8, 1, 1); push_src(2, 8, 1, 1);
        push_exp(2, 8, 1, 1); push_exp(0, 8, 1, 1);
        wait_drain("to_rr_drain");

        // Fairness: port 2 single-beat frame, re-asserts at once, port 0 waiting.
        gnt_q.push_back(4'b0100);
        gnt_q.push_back(4'b0001);
        gnt_q.push_back(4'b0100);
        push_src(2, 9, 1, 1); push_src(2, 10, 1, 1); push_src(0, 9, 1, 1);
        push_exp(2, 9, 1, 1); push_exp(0, 9, 1, 1); push_exp(2, 10, 1, 1);
        wait_drain("fair_drain");

        // Reset mid-frame on port 3 (rr_ptr=3 beforehand).
        gnt_q.push_back(4'b1000);
        push_src(3, 6, 6, 1);
        push_exp(3, 6, 6, 1);
        wait_beat(mk(3, 6, 2), "rst_reach_beat3");
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_tvalid", 32'(egress_tvalid), 32'd0);
        chk("rst_mid_grant", 32'(grant_onehot), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_tready", 32'(req_tready), 32'd0);
        flush = 1;
        exp_q.delete();
        gnt_q.delete();
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        gnt_q.push_back(4'b0100);
        gnt_q.push_back(4'b1000);
        push_src(2, 7, 2, 1); push_src(3, 7, 2, 1);
        push_exp(2, 7, 2, 1); push_exp(3, 7, 2, 1);
        wait_drain("post_rst_drain");
`ifdef EGRESS_ARB_STATS_EN
        chk("stat_frames", 32'(stat_frames[63:32]), {16'd1, 16'd1});
        chk("stat_frames_lo", 32'(stat_frames[31:0]), 32'd0);
        chk("stat_timeouts_all", 32'(stat_timeouts), 32'd0);
`endif
        chk("gnt_q_empty", 32'(gnt_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
